// File: rtl/ccff_loader.sv
// ccff_loader: serialises a sentinel and then configuration words onto the
// fabric configuration chain, and checks the sentinel as it emerges on the tail.
module ccff_loader #(
  parameter int                CHAIN_LEN = 1024,
  parameter int                WORD_W    = 32,
  parameter int                SENT_W    = 16,
  parameter logic [SENT_W-1:0] SENTINEL  = 16'hA5C3
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              pass
);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int PAD    = NWORDS * WORD_W - CHAIN_LEN;
  localparam int TOTAL  = CHAIN_LEN + SENT_W;
  localparam int EW     = $clog2(TOTAL + 1);
  localparam int BW     = $clog2(WORD_W + 1);
  localparam int CW     = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SENT, S_DATA, S_FIN} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     en_cnt;      // enabled shifts completed since start
  logic [EW-1:0]     issued;      // bits put on the head so far, incl. this cycle
  logic [BW-1:0]     sh_cnt;      // bits still waiting in shreg
  logic [CW-1:0]     wcnt;        // words accepted this load
  logic [WORD_W-1:0] shreg, buf_q;
  logic              buf_full, buf_first, mismatch, pass_q;
  logic              go, emit_sent, emit_data, xfer, shift, reload;
  logic [EW-1:0]     sidx, tidx;
  logic [SENT_W-1:0] sent_shr, tail_shr;
  logic [BW-1:0]     load_len_m1;

  assign issued      = en_cnt + {{(EW-1){1'b0}}, ccff_shift_en};
  assign sidx        = EW'(SENT_W - 1) - issued;
  assign tidx        = EW'(TOTAL - 1) - en_cnt;
  assign sent_shr    = SENTINEL >> sidx;
  assign tail_shr    = SENTINEL >> tidx;
  assign xfer        = word_valid & word_ready;
  assign shift       = emit_data & (sh_cnt != '0);
  assign reload      = emit_data & (sh_cnt == '0) & buf_full;
  // The first word was already left-aligned at capture, so only its low bits count.
  assign load_len_m1 = buf_first ? BW'(WORD_W - PAD - 1) : BW'(WORD_W - 1);

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);
  assign pass = (state == S_FIN) ? !mismatch : pass_q;

  // State register.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next state, word_ready, and which bit source feeds the head next cycle.
  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    go         = 1'b0;
    emit_sent  = 1'b0;
    emit_data  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        go        = 1'b1;
        state_nxt = S_SENT;
      end
      S_SENT: begin
        word_ready = !buf_full && (wcnt < CW'(NWORDS));
        if (issued < EW'(SENT_W)) emit_sent = 1'b1;
        else begin
          emit_data = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        word_ready = !buf_full && (wcnt < CW'(NWORDS));
        if (issued == EW'(TOTAL)) state_nxt = S_FIN;
        else                      emit_data = 1'b1;
      end
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: head/enable registers, shift register, holding buffer, tail check.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      en_cnt        <= '0;
      sh_cnt        <= '0;
      wcnt          <= '0;
      shreg         <= '0;
      buf_q         <= '0;
      buf_full      <= 1'b0;
      buf_first     <= 1'b0;
      mismatch      <= 1'b0;
      pass_q        <= 1'b0;
    end else if (go) begin
      ccff_head     <= SENTINEL[SENT_W-1];
      ccff_shift_en <= 1'b1;
      en_cnt        <= '0;
      sh_cnt        <= '0;
      wcnt          <= '0;
      buf_full      <= 1'b0;
      mismatch      <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      if (ccff_shift_en) begin
        en_cnt <= en_cnt + 1'b1;
        if (en_cnt >= EW'(CHAIN_LEN) && en_cnt < EW'(TOTAL) && ccff_tail != tail_shr[0])
          mismatch <= 1'b1;
      end

      if (emit_sent) begin
        ccff_head     <= sent_shr[0];
        ccff_shift_en <= 1'b1;
      end else if (shift) begin
        ccff_head     <= shreg[WORD_W-1];
        shreg         <= shreg << 1;
        sh_cnt        <= sh_cnt - 1'b1;
        ccff_shift_en <= 1'b1;
      end else if (reload) begin
        ccff_head     <= buf_q[WORD_W-1];
        shreg         <= buf_q << 1;
        sh_cnt        <= load_len_m1;
        ccff_shift_en <= 1'b1;
      end else begin
        // Bubble (or end of load): head holds, chain does not move.
        ccff_shift_en <= 1'b0;
        if (state == S_FIN) ccff_head <= 1'b0;
      end

      if (xfer) begin
        buf_q     <= (wcnt == '0) ? (word_data << PAD) : word_data;
        buf_first <= (wcnt == '0);
        buf_full  <= 1'b1;
        wcnt      <= wcnt + 1'b1;
      end else if (reload) begin
        buf_full  <= 1'b0;
      end

      if (state == S_FIN) pass_q <= !mismatch;
    end
  end
endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: 40-flop behavioural chain on head/tail, scripted
// table rows, reset/start corner sequences and randomized word/valid traffic.
module tb_ccff_loader;
  logic        prog_clk = 1'b0;
  logic        prog_reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        word_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, pass;

  int errors = 0;
  int checks = 0;

  // Fabric chain model: shifts head in only on enabled cycles.
  logic [63:0] chain;
  int          mlen = 40;
  logic        tail_stuck = 1'b0;
  assign ccff_tail = tail_stuck ? 1'b1 : chain[mlen-1];

  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[62:0], ccff_head};
  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(40), .WORD_W(32), .SENT_W(16), .SENTINEL(16'hA5C3)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .pass(pass)
  );

  typedef struct {
    logic [31:0] w0, w1;
    int          hold;      // earliest cycle the second/third word is offered
    logic        stuck;
    int          len;
    int          exp_done;
    logic        exp_pass;
    int          exp_bub;
  } vec_t;

  // Results of the last run_load.
  logic [55:0] r_bits;
  int          r_nbits, r_bub, r_done, r_xfer;
  logic        r_pass, r_busy_after, r_pass_after;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One load: start, feed three words (third must be refused), collect head bits.
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int hold,
                          input bit rnd, input int rst_at, input int start_at);
    logic [31:0] words [3];
    int widx;
    logic xf;
    words[0] = w0; words[1] = w1; words[2] = 32'hDEAD_BEEF;
    widx = 0; r_bits = '0; r_nbits = 0; r_bub = 0; r_done = 0; r_xfer = 0; r_pass = 1'b0;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 300 && r_done == 0; cyc++) begin
      if (ccff_shift_en) begin r_bits = {r_bits[54:0], ccff_head}; r_nbits++; end
      else if (busy && !done) r_bub++;
      if (done) begin r_done = cyc; r_pass = pass; end
      word_valid = (widx < 3) && (widx == 0 || cyc >= hold) && (!rnd || $urandom_range(0, 3) != 0);
      word_data  = (widx < 3) ? words[widx] : 32'h0;
      start      = (cyc == start_at);
      if (cyc == rst_at) prog_reset = 1'b0;
      xf = word_valid && word_ready;
      @(posedge prog_clk); #1;
      if (xf) begin widx++; r_xfer++; end
      if (cyc == rst_at) break;
    end
    word_valid = 1'b0;
    start = 1'b0;
    r_busy_after = busy;
    r_pass_after = pass;
  endtask

  task automatic check_load(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input int exp_done, input logic exp_pass, input int exp_bub, input bit chk_chain);
    chk({tag, " head stream"}, {8'h0, r_bits}, {8'h0, 16'hA5C3, w0[7:0], w1});
    chk({tag, " enabled count"}, r_nbits, 56);
    if (chk_chain) chk({tag, " chain"}, chain[39:0], {w0[7:0], w1});
    chk({tag, " done cycle"}, r_done, exp_done);
    chk({tag, " pass"}, r_pass, exp_pass);
    chk({tag, " bubbles"}, r_bub, exp_bub);
    chk({tag, " words taken"}, r_xfer, 2);
    chk({tag, " busy after"}, r_busy_after, 0);
    chk({tag, " pass held"}, r_pass_after, exp_pass);
  endtask

  initial begin
    vec_t vt [4];
    logic [31:0] a, b;
    vt[0] = '{32'h0000_00AB, 32'hCDEF_1234,  0, 1'b0, 40, 57, 1'b1, 0};
    vt[1] = '{32'h0000_00AB, 32'hCDEF_1234, 28, 1'b0, 40, 62, 1'b1, 5};
    vt[2] = '{32'h0000_00AB, 32'hCDEF_1234,  0, 1'b0, 39, 57, 1'b0, 0};
    vt[3] = '{32'h0000_00AB, 32'hCDEF_1234,  0, 1'b1, 40, 57, 1'b0, 0};

    repeat (3) @(posedge prog_clk);
    #1;
    chk("reset outputs", {word_ready, ccff_head, ccff_shift_en, busy, done, pass}, 6'b0);
    prog_reset = 1'b1;
    @(posedge prog_clk); #1;

    foreach (vt[i]) begin
      mlen = vt[i].len;
      tail_stuck = vt[i].stuck;
      run_load(vt[i].w0, vt[i].w1, vt[i].hold, 1'b0, 0, 0);
      check_load($sformatf("row%0d", i), vt[i].w0, vt[i].w1, vt[i].exp_done,
                 vt[i].exp_pass, vt[i].exp_bub, vt[i].len == 40);
      @(posedge prog_clk); #1;
    end
    mlen = 40;
    tail_stuck = 1'b0;

    // Reset mid-load at enabled cycle 20, then a clean reload.
    run_load(32'h0000_005A, 32'h1357_9BDF, 0, 1'b0, 20, 0);
    chk("midload reset outputs", {word_ready, ccff_head, ccff_shift_en, busy, done, pass}, 6'b0);
    prog_reset = 1'b1;
    @(posedge prog_clk); #1;
    run_load(32'h0000_00AB, 32'hCDEF_1234, 0, 1'b0, 0, 0);
    check_load("after reset", 32'h0000_00AB, 32'hCDEF_1234, 57, 1'b1, 0, 1'b1);
    @(posedge prog_clk); #1;

    // start pulsed in the middle of DATA must be ignored.
    run_load(32'h0000_0017, 32'h8899_AABB, 0, 1'b0, 0, 30);
    check_load("start in data", 32'h0000_0017, 32'h8899_AABB, 57, 1'b1, 0, 1'b1);
    @(posedge prog_clk); #1;

    // Random words with random valid gaps: each stall adds exactly one cycle.
    for (int n = 0; n < 6; n++) begin
      a = $urandom;
      b = $urandom;
      run_load(a, b, 0, 1'b1, 0, 0);
      check_load($sformatf("rand%0d", n), a, b, 57 + r_bub, 1'b1, r_bub, 1'b1);
      @(posedge prog_clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
